// File: rtl/ntt_pkg.sv
// Shared coefficient type and modular add/sub helpers for the NTT datapath.
// All operands are expected in [0, q-1]; the helpers keep results in that range.
package ntt_pkg;

  localparam int DATA_W = 32;
  localparam int Q      = 7681;

  typedef logic [DATA_W-1:0] coeff_t;

  // One extra bit holds the carry so a+b never wraps before the reduction.
  function automatic coeff_t mod_add(input coeff_t a, input coeff_t b,
                                     input coeff_t q = coeff_t'(Q));
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, q}) begin
      sum = sum - {1'b0, q};
    end
    return sum[DATA_W-1:0];
  endfunction

  function automatic coeff_t mod_sub(input coeff_t a, input coeff_t b,
                                     input coeff_t q = coeff_t'(Q));
    coeff_t diff;
    if (a >= b) begin
      diff = a - b;
    end else begin
      diff = a + q - b;
    end
    return diff;
  endfunction

endpackage

// File: rtl/ntt_sync_fifo.sv
// Small synchronous FIFO used as the butterfly output buffer.
// The head entry is presented combinationally on rdata; pointers wrap modulo DEPTH.
module ntt_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_FULL);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is cleared on reset so the head reads zero while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ntt_butterfly_addsub.sv
// Cooley-Tukey butterfly back end: aligns a with the registered twiddle product r,
// emits (a+r) mod q and (a-r) mod q, and buffers results behind a credit counter.
module ntt_butterfly_addsub #(
  parameter int DATA_W    = ntt_pkg::DATA_W,
  parameter int MODULUS   = ntt_pkg::Q,
  parameter int MUL_LAT   = 1,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_in,
  output logic              mul_en,
  input  logic [DATA_W-1:0] mul_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] even_out,
  output logic [DATA_W-1:0] odd_out
);

  import ntt_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and in_ready comes only from a flop.

  localparam int TOK_W = $clog2(BUF_DEPTH + 1);
  localparam logic [TOK_W-1:0]  TOK_MAX = TOK_W'(BUF_DEPTH);
  localparam logic [TOK_W-1:0]  TOK_ONE = TOK_W'(1);
  localparam logic [DATA_W-1:0] MOD_C   = DATA_W'(MODULUS);

  logic              accept;
  logic              pop;
  logic [TOK_W-1:0]  tok_q, tok_d;
  logic              in_ready_q, in_ready_d;

  logic [DATA_W-1:0] dly_a_q [MUL_LAT];
  logic [DATA_W-1:0] dly_a_d [MUL_LAT];
  logic [MUL_LAT-1:0] dly_v_q, dly_v_d;

  logic              stg_v;
  logic [DATA_W-1:0] stg_a;
  logic [DATA_W-1:0] res_even;
  logic [DATA_W-1:0] res_odd;

  logic [2*DATA_W-1:0] fifo_rdata;
  logic                fifo_empty;
  logic                fifo_full;

  assign accept    = in_valid & in_ready_q;
  assign mul_en    = accept;
  assign in_ready  = in_ready_q;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign stg_v     = dly_v_q[MUL_LAT-1];
  assign stg_a     = dly_a_q[MUL_LAT-1];
  assign {even_out, odd_out} = fifo_rdata;

  // Tokens count everything accepted but not yet popped, in flight or buffered,
  // so a result always has a free buffer slot when it reaches the last stage.
  always_comb begin
    tok_d = tok_q;
    case ({accept, pop})
      2'b10:   tok_d = tok_q + TOK_ONE;
      2'b01:   tok_d = tok_q - TOK_ONE;
      default: tok_d = tok_q;
    endcase
    in_ready_d = (tok_d < TOK_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tok_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      tok_q      <= tok_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Delay line for a: stage MUL_LAT-1 lines up with the multiplier output.
  always_comb begin
    dly_v_d    = '0;
    dly_a_d    = dly_a_q;
    dly_v_d[0] = accept;
    dly_a_d[0] = accept ? a_in : dly_a_q[0];
    for (int i = 1; i < MUL_LAT; i++) begin
      dly_v_d[i] = dly_v_q[i-1];
      dly_a_d[i] = dly_a_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly_v_q <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        dly_a_q[i] <= '0;
      end
    end else begin
      dly_v_q <= dly_v_d;
      for (int i = 0; i < MUL_LAT; i++) begin
        dly_a_q[i] <= dly_a_d[i];
      end
    end
  end

  always_comb begin
    res_even = mod_add(stg_a, mul_result, MOD_C);
    res_odd  = mod_sub(stg_a, mul_result, MOD_C);
  end

  ntt_sync_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (BUF_DEPTH)
  ) u_out_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (stg_v),
    .pop   (pop),
    .wdata ({res_even, res_odd}),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  a_in_range: assert property (@(posedge clk) disable iff (!rst)
    accept |-> (a_in < MOD_C));

  mul_in_range: assert property (@(posedge clk) disable iff (!rst)
    stg_v |-> (mul_result < MOD_C));

  no_overflow: assert property (@(posedge clk) disable iff (!rst)
    stg_v |-> !fifo_full);

endmodule

// File: tb/tb_ntt_butterfly_addsub.sv
// Bench for ntt_butterfly_addsub: registered multiplier model, vector table,
// hand-written back-pressure/reset sequences and a long random run.
module tb_ntt_butterfly_addsub;

  localparam int W = 32;
  localparam int Q = 7681;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_in = '0;
  logic         mul_en;
  logic [W-1:0] mul_result;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] even_out;
  logic [W-1:0] odd_out;

  logic [W-1:0] b_in = '0;
  logic [W-1:0] w_in = '0;
  logic [W-1:0] mul_q = '0;

  int errors = 0;
  int checks = 0;
  int pushed = 0;
  int popped = 0;

  logic [2*W-1:0] exp_q[$];

  always #5 clk = ~clk;

  ntt_butterfly_addsub dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .mul_en     (mul_en),
    .mul_result (mul_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .even_out   (even_out),
    .odd_out    (odd_out)
  );

  // Registered twiddle multiplier: one cycle from mul_en to result, holds otherwise.
  always @(posedge clk) begin
    if (mul_en) mul_q <= W'((longint'(w_in) * longint'(b_in)) % longint'(Q));
  end
  assign mul_result = mul_q;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input longint a, input longint r);
    longint e;
    longint o;
    e = (a + r) % Q;
    o = (a - r + Q) % Q;
    return {W'(e), W'(o)};
  endfunction

  // Scoreboard: compare pops first so a same-cycle push never lands at the head.
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        popped++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_output", 64'(out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("sb_even", 64'(even_out), 64'(e[2*W-1:W]));
          check("sb_odd", 64'(odd_out), 64'(e[W-1:0]));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(longint'(a_in), (longint'(w_in) * longint'(b_in)) % Q));
        pushed++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] w);
    in_valid = v;
    a_in     = a;
    b_in     = b;
    w_in     = w;
  endtask

  task automatic set_rand_op(input logic v);
    set_op(v, W'($urandom_range(Q-1, 0)), W'($urandom_range(Q-1, 0)),
           W'($urandom_range(Q-1, 0)));
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] r;
    logic [W-1:0] even;
    logic [W-1:0] odd;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [2*W-1:0] head;
    int p0;
    int q0;
    int cnt;

    vecs[0] = '{a: 100,  r: 200,  even: 300, odd: 7581};
    vecs[1] = '{a: 7680, r: 1,    even: 0,   odd: 7679};
    vecs[2] = '{a: 0,    r: 0,    even: 0,   odd: 0};
    vecs[3] = '{a: 5,    r: 5,    even: 10,  odd: 0};
    vecs[4] = '{a: 3840, r: 3841, even: 0,   odd: 7680};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_even", 64'(even_out), 64'(0));
    check("rst_odd", 64'(odd_out), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("release_in_ready_low", 64'(in_ready), 64'(0));
    tick();
    check("release_in_ready_high", 64'(in_ready), 64'(1));

    // Vector table: single ops, latency and value checks
    for (int i = 0; i < 5; i++) begin
      set_op(1'b1, vecs[i].a, vecs[i].r, 1);
      @(negedge clk);
      check("vec_ready", 64'(in_ready), 64'(1));
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("vec_lat_c1", 64'(out_valid), 64'(0));
      @(negedge clk);
      check("vec_lat_c2", 64'(out_valid), 64'(1));
      check("vec_even", 64'(even_out), 64'(vecs[i].even));
      check("vec_odd", 64'(odd_out), 64'(vecs[i].odd));
      tick();
      tick();
    end

    // 16 back-to-back ops at full rate
    p0 = popped;
    for (int i = 0; i < 16; i++) begin
      set_rand_op(1'b1);
      @(negedge clk);
      check("b2b_ready", 64'(in_ready), 64'(1));
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("b2b_pops", 64'(popped - p0), 64'(16));
    check("b2b_drained", 64'(exp_q.size()), 64'(0));

    // Back-pressure: 4 credits, then stall with a stable head
    out_ready = 1'b0;
    head = '0;
    for (int c = 0; c < 6; c++) begin
      set_rand_op(1'b1);
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'(c < 4));
      check("bp_mul_en", 64'(mul_en), 64'(c < 4));
      if (c == 2) head = {even_out, odd_out};
      if (c == 5) begin
        check("bp_out_valid", 64'(out_valid), 64'(1));
        check("bp_head_stable", 64'({even_out, odd_out}), 64'(head));
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_rdy_still_low", 64'(in_ready), 64'(0));
    tick();
    @(negedge clk);
    check("bp_rdy_reasserted", 64'(in_ready), 64'(1));
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 10) begin
      tick();
      cnt++;
    end
    check("bp_drained", 64'(exp_q.size()), 64'(0));
    tick();

    // Reset with results in flight and buffered
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      set_rand_op(1'b1);
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_even", 64'(even_out), 64'(0));
    check("midrst_odd", 64'(odd_out), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(0));
    tick();
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("midrst_no_stale_output", 64'(cnt), 64'(0));
    check("midrst_in_ready_back", 64'(in_ready), 64'(1));
    tick();

    // Random traffic
    p0 = pushed;
    q0 = popped;
    cnt = 0;
    while (cnt < 60000 && (pushed - p0) < 10000) begin
      set_rand_op($urandom_range(99, 0) < 70);
      out_ready = ($urandom_range(99, 0) < 75);
      tick();
      cnt++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("rand_accepted", 64'(pushed - p0), 64'(10000));
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 20) begin
      tick();
      cnt++;
    end
    check("rand_drained", 64'(exp_q.size()), 64'(0));
    check("rand_counts_equal", 64'(popped - q0), 64'(pushed - p0));
    @(negedge clk);
    check("rand_idle_out_valid", 64'(out_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
